// File: rtl/data_cache_ctrl.sv
// Direct-mapped, one-word-per-line, write-through / no-write-allocate data
// cache controller sitting in the MEM stage of a pipeline. Loads that hit
// complete combinationally; misses and all stores go to backing memory
// through a simple req/ready handshake and stall the pipeline via hit=0.
// Optional read statistics counters are compiled in with DCACHE_STATS_EN.
module data_cache_ctrl #(
  parameter int LINES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        hit,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] rd_hits,
  output logic [15:0] rd_misses
`endif
);

  localparam int DATA_W = 32;
  localparam int IDX    = $clog2(LINES);
  localparam int TAG_W  = 30 - IDX;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_REQ  = 2'd1;
  localparam logic [1:0] WR_REQ  = 2'd2;
  localparam logic [1:0] WR_DONE = 2'd3;

  logic [1:0]        state;
  logic [1:0]        nextState;
  logic [LINES-1:0]  validBits;
  logic [TAG_W-1:0]  tagMem  [LINES];
  logic [DATA_W-1:0] dataMem [LINES];
  logic [IDX-1:0]    lineIdx;
  logic [TAG_W-1:0]  lineTag;
  logic              lookupHit;
  logic              justFilled;

  assign lineIdx   = addr[2 +: IDX];
  assign lineTag   = addr[31 -: TAG_W];
  assign lookupHit = validBits[lineIdx] && (tagMem[lineIdx] == lineTag);
  assign readData  = dataMem[lineIdx];

  // Next-state and handshake outputs; request fields simply follow the
  // pipeline inputs, which the stalled pipeline holds steady.
  always_comb begin
    nextState = state;
    hit       = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr & ~32'h3;
    mem_wdata = writeData;
    case (state)
      IDLE: begin
        if (MemWrite)
          nextState = WR_REQ;
        else if (MemRead) begin
          if (lookupHit) hit = 1'b1;
          else           nextState = RD_REQ;
        end else
          hit = 1'b1;
      end
      RD_REQ: begin
        mem_req = 1'b1;
        if (mem_ready) nextState = IDLE;
      end
      WR_REQ: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) nextState = WR_DONE;
      end
      WR_DONE: begin
        hit       = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Control state: FSM, valid bits and the post-refill marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      validBits  <= '0;
      justFilled <= 1'b0;
    end else begin
      state      <= nextState;
      justFilled <= (state == RD_REQ) && mem_ready;
      if ((state == RD_REQ) && mem_ready)
        validBits[lineIdx] <= 1'b1;
    end
  end

  // Line storage: refill writes tag+data, a store hit updates data only.
  always_ff @(posedge clk) begin
    if ((state == RD_REQ) && mem_ready) begin
      tagMem[lineIdx]  <= lineTag;
      dataMem[lineIdx] <= mem_rdata;
    end else if ((state == WR_REQ) && mem_ready && lookupHit) begin
      dataMem[lineIdx] <= writeData;
    end
  end

`ifdef DCACHE_STATS_EN
  function automatic logic [15:0] satInc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic loadInIdle;
  assign loadInIdle = (state == IDLE) && MemRead && !MemWrite;

  // Read statistics; the hit that follows a refill is the same load, not a new one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_hits   <= '0;
      rd_misses <= '0;
    end else begin
      if (loadInIdle && lookupHit && !justFilled) rd_hits   <= satInc(rd_hits);
      if (loadInIdle && !lookupHit)               rd_misses <= satInc(rd_misses);
    end
  end
`endif

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Bench for data_cache_ctrl (LINES=16): table of accesses with a backing
// memory model and a scoreboard of expected load data, plus hand-written
// reset and statistics sequences (statistics only with DCACHE_STATS_EN).
module tb_data_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemRead, MemWrite;
  logic [31:0] addr, writeData, readData;
  logic        hit, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [15:0] rd_hits, rd_misses;
`endif

  data_cache_ctrl #(.LINES(16)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .addr(addr), .writeData(writeData), .readData(readData), .hit(hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
`ifdef DCACHE_STATS_EN
    , .rd_hits(rd_hits), .rd_misses(rd_misses)
`endif
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  logic [31:0] expQ[$];
  logic [31:0] memArr[logic [31:0]];

  typedef struct {
    string       name;
    logic        isWr;
    logic [31:0] a;
    logic [31:0] wd;
    int          lat;
    logic        expMiss;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    else passed++;
  endtask

  function automatic logic [31:0] memRead(input logic [31:0] w);
    return memArr.exists(w) ? memArr[w] : ~w;
  endfunction

  // One pipeline access: hold the request until hit, acting as backing memory.
  task automatic doAccess(input string nm, input logic isWr, input logic [31:0] a,
                          input logic [31:0] wd, input int lat, input logic expMiss,
                          input logic [31:0] expData);
    int stalls = 0;
    int reqCycles = 0;
    logic sawReq = 1'b0;
    logic stable = 1'b1;
    logic done = 1'b0;
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    addr = a; writeData = wd; MemWrite = isWr; MemRead = !isWr;
    if (!isWr) expQ.push_back(expData);
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (hit) done = 1'b1;
      else begin
        stalls++;
        if (mem_req) begin
          if (!sawReq) begin
            chk({nm, ".mem_we"}, {31'd0, mem_we}, {31'd0, isWr});
            chk({nm, ".mem_addr"}, mem_addr, wa);
            if (isWr) chk({nm, ".mem_wdata"}, mem_wdata, wd);
            sawReq = 1'b1;
          end
          if (mem_we !== isWr || mem_addr !== wa || (isWr && mem_wdata !== wd)) stable = 1'b0;
          reqCycles++;
          if (reqCycles == lat) begin
            mem_ready = 1'b1;
            if (isWr) memArr[wa] = wd;
            else mem_rdata = memRead(wa);
          end
        end
        @(posedge clk); #1;
        mem_ready = 1'b0;
        mem_rdata = $urandom;
      end
    end
    chk({nm, ".done"}, {31'd0, done}, 32'd1);
    if (done) begin
      if (!isWr) chk({nm, ".readData"}, readData, expQ.pop_front());
      else       chk({nm, ".wrDoneReq"}, {31'd0, mem_req}, 32'd0);
      chk({nm, ".memAccess"}, {31'd0, sawReq}, {31'd0, isWr | expMiss});
      chk({nm, ".stalls"}, stalls, (isWr || expMiss) ? lat + 1 : 0);
      if (sawReq) chk({nm, ".stable"}, {31'd0, stable}, 32'd1);
      @(posedge clk); #1;
    end
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; addr = '0; writeData = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    memArr[32'h40] = 32'hDEAD_BEEF;
    memArr[32'h80] = 32'hCAFE_F00D;

    vecs[0]  = '{"ldMiss40",   1'b0, 32'h40, 0, 3, 1'b1, 32'hDEAD_BEEF};
    vecs[1]  = '{"ldHit40",    1'b0, 32'h40, 0, 1, 1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{"stHit40",    1'b1, 32'h40, 32'h1234_5678, 2, 1'b0, 0};
    vecs[3]  = '{"ldAfterSt",  1'b0, 32'h40, 0, 1, 1'b0, 32'h1234_5678};
    vecs[4]  = '{"stMiss80",   1'b1, 32'h80, 32'h0BAD_F00D, 1, 1'b0, 0};
    vecs[5]  = '{"ldNoAlloc",  1'b0, 32'h80, 0, 2, 1'b1, 32'h0BAD_F00D};
    vecs[6]  = '{"conflict40", 1'b0, 32'h40, 0, 1, 1'b1, 32'h1234_5678};
    vecs[7]  = '{"conflict80", 1'b0, 32'h80, 0, 1, 1'b1, 32'h0BAD_F00D};
    vecs[8]  = '{"conflict40b",1'b0, 32'h40, 0, 4, 1'b1, 32'h1234_5678};
    vecs[9]  = '{"ldMiss3C",   1'b0, 32'h3C, 0, 2, 1'b1, 32'hFFFF_FFC3};
    vecs[10] = '{"ldByteOfs",  1'b0, 32'h3D, 0, 1, 1'b0, 32'hFFFF_FFC3};
    vecs[11] = '{"stHit3C",    1'b1, 32'h3E, 32'hAAAA_5555, 3, 1'b0, 0};
    vecs[12] = '{"ldHit3C",    1'b0, 32'h3C, 0, 1, 1'b0, 32'hAAAA_5555};
    vecs[13] = '{"ldMaxTag",   1'b0, 32'hFFFF_FFC0, 0, 1, 1'b1, 32'h0000_003F};

    #12;
    chk("rst.mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst.mem_we",  {31'd0, mem_we},  32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("idle.hit", {31'd0, hit}, 32'd1);
    @(posedge clk); #1;

    foreach (vecs[i])
      doAccess(vecs[i].name, vecs[i].isWr, vecs[i].a, vecs[i].wd, vecs[i].lat,
               vecs[i].expMiss, vecs[i].expData);

    // mem_ready pulsing while idle must not fill any line
    addr = 32'h300; mem_ready = 1'b1; mem_rdata = 32'h1111_1111;
    repeat (2) @(posedge clk);
    #1; mem_ready = 1'b0;
    doAccess("readyIdle", 1'b0, 32'h300, 0, 1, 1'b1, ~32'h300);

    // Reset in the middle of a refill, with mem_ready up at the reset edge
    doAccess("fill44", 1'b0, 32'h44, 0, 1, 1'b1, ~32'h44);
    addr = 32'h48; MemRead = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rdReq.mem_req", {31'd0, mem_req}, 32'd1);
    #2; rst_n = 1'b0; #1;
    chk("midRst.mem_req", {31'd0, mem_req}, 32'd0);
    chk("midRst.mem_we",  {31'd0, mem_we},  32'd0);
    mem_ready = 1'b1; mem_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    mem_ready = 1'b0; MemRead = 1'b0; rst_n = 1'b1;
    doAccess("postRst48", 1'b0, 32'h48, 0, 2, 1'b1, ~32'h48);
    doAccess("postRst44", 1'b0, 32'h44, 0, 1, 1'b1, ~32'h44);

`ifdef DCACHE_STATS_EN
    rst_n = 1'b0; #1;
    chk("stat.rstHits", {16'd0, rd_hits}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    doAccess("s0", 1'b0, 32'h200, 0, 1, 1'b1, ~32'h200);
    doAccess("s1", 1'b0, 32'h200, 0, 1, 1'b0, ~32'h200);
    doAccess("s2", 1'b0, 32'h204, 0, 2, 1'b1, ~32'h204);
    doAccess("s3", 1'b0, 32'h204, 0, 1, 1'b0, ~32'h204);
    doAccess("s4", 1'b0, 32'h208, 0, 1, 1'b1, ~32'h208);
    doAccess("s5", 1'b0, 32'h208, 0, 1, 1'b0, ~32'h208);
    doAccess("s6", 1'b0, 32'h204, 0, 1, 1'b0, ~32'h204);
    doAccess("s7", 1'b0, 32'h200, 0, 1, 1'b0, ~32'h200);
    doAccess("s8", 1'b1, 32'h200, 32'h5, 1, 1'b0, 0);
    chk("stat.misses", {16'd0, rd_misses}, 32'd3);
    chk("stat.hits",   {16'd0, rd_hits},   32'd5);
    addr = 32'h200; MemRead = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    chk("stat.hitsSat", {16'd0, rd_hits},   32'hFFFF);
    chk("stat.missKeep",{16'd0, rd_misses}, 32'd3);
    MemRead = 1'b0;
`endif

    chk("sbEmpty", expQ.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
